// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential execute-stage ALU: operation encoding,
// data word type and the operation-class decode used by the FSM and engine.
package seq_alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

    // Encodings 0-7 belong to the original single-cycle ALU; new ops are appended.
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SLT    = 5'd6,
        OP_SLTU   = 5'd7,
        OP_SRL    = 5'd8,
        OP_SRA    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } alu_op_t;

    typedef enum logic [1:0] {
        CLASS_SINGLE,
        CLASS_MUL,
        CLASS_DIV
    } op_class_t;

    function automatic op_class_t op_class(alu_op_t op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: return CLASS_MUL;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU:     return CLASS_DIV;
            default:                              return CLASS_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_muldiv_engine.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with the sign fix-up on the last step.
module seq_alu_muldiv_engine
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic               busy, is_div, neg, sel_alt;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mag;
    logic [2*WIDTH-1:0] acc;

    logic               start_div, rem_op, signed_a, signed_b, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;

    always_comb begin : start_decode
        start_div = (op_class(op) == CLASS_DIV);
        rem_op    = op inside {OP_REM, OP_REMU};
        signed_a  = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        signed_b  = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        a_neg     = signed_a && a[WIDTH-1];
        b_neg     = signed_b && b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] acc_next, product;
    logic [WIDTH-1:0]   div_pick;

    always_comb begin : iterate
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mag};
        if (!is_div)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
        else
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        product  = neg ? -acc_next : acc_next;
        div_pick = sel_alt ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
        if (is_div)
            result = neg ? -div_pick : div_pick;
        else
            result = sel_alt ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
        done = busy && (count == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            is_div  <= 1'b0;
            neg     <= 1'b0;
            sel_alt <= 1'b0;
            count   <= '0;
            mag     <= '0;
            acc     <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            is_div  <= start_div;
            neg     <= rem_op ? a_neg : (a_neg ^ b_neg);
            sel_alt <= op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
            count   <= LAST_COUNT;
            mag     <= start_div ? mag_b : mag_a;
            acc     <= {{WIDTH{1'b0}}, (start_div ? mag_a : mag_b)};
        end else if (busy) begin
            acc <= acc_next;
            if (count == '0)
                busy <= 1'b0;
            else
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle datapath and control FSM, with
// multiply/divide delegated to the iterative engine.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  alu_op_t               i_op,
    input  logic [DATA_WIDTH-1:0] i_operandA,
    input  logic [DATA_WIDTH-1:0] i_operandB,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t                state, state_next;
    op_class_t             op_cls;
    logic                  accept, start, load_result, eng_done;
    logic                  div_by_zero, div_overflow, special_div;
    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] single_result, result_next, eng_result;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin : single_cycle
        shamt         = i_operandB[SHW-1:0];
        div_by_zero   = (i_operandB == '0);
        div_overflow  = (i_op inside {OP_DIV, OP_REM}) && (&i_operandB) &&
                        (i_operandA == {1'b1, {(DATA_WIDTH-1){1'b0}}});
        single_result = '0;
        case (i_op)
            OP_ADD:  single_result = i_operandA + i_operandB;
            OP_SUB:  single_result = i_operandA - i_operandB;
            OP_AND:  single_result = i_operandA & i_operandB;
            OP_OR:   single_result = i_operandA | i_operandB;
            OP_XOR:  single_result = i_operandA ^ i_operandB;
            OP_SLL:  single_result = i_operandA << shamt;
            OP_SRL:  single_result = i_operandA >> shamt;
            OP_SRA:  single_result = $signed(i_operandA) >>> shamt;
            OP_SLT:  single_result = {{(DATA_WIDTH-1){1'b0}}, $signed(i_operandA) < $signed(i_operandB)};
            OP_SLTU: single_result = {{(DATA_WIDTH-1){1'b0}}, i_operandA < i_operandB};
            // Divide special cases resolve here without iterating.
            OP_DIV, OP_DIVU: single_result = div_by_zero ? '1 : i_operandA;
            OP_REM, OP_REMU: single_result = div_by_zero ? i_operandA : '0;
            default: single_result = '0;
        endcase
    end

    always_comb begin : fsm_next
        op_cls      = op_class(i_op);
        special_div = div_by_zero || div_overflow;
        o_valid     = (state == ST_DONE);
        o_ready     = (state == ST_IDLE) || ((state == ST_DONE) && i_ready);
        accept      = i_valid && o_ready;
        state_next  = state;
        start       = 1'b0;
        load_result = 1'b0;
        result_next = single_result;
        case (state)
            ST_MUL, ST_DIV: begin
                if (eng_done) begin
                    state_next  = ST_DONE;
                    load_result = 1'b1;
                    result_next = eng_result;
                end
            end
            default: begin
                if ((state == ST_DONE) && i_ready)
                    state_next = ST_IDLE;
                if (accept) begin
                    if (op_cls == CLASS_MUL) begin
                        state_next = ST_MUL;
                        start      = 1'b1;
                    end else if ((op_cls == CLASS_DIV) && !special_div) begin
                        state_next = ST_DIV;
                        start      = 1'b1;
                    end else begin
                        state_next  = ST_DONE;
                        load_result = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            o_result <= '0;
        end else begin
            state <= state_next;
            if (load_result)
                o_result <= result_next;
        end
    end

    seq_alu_muldiv_engine #(
        .WIDTH (DATA_WIDTH)
    ) muldiv_engine (
        .clk    (i_clock),
        .rst    (i_reset),
        .start  (start),
        .op     (i_op),
        .a      (i_operandA),
        .b      (i_operandB),
        .done   (eng_done),
        .result (eng_result)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases plus randomized traffic
// checked against an arithmetic reference model of the ALU operations.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 32;

    logic    i_clock = 1'b0;
    logic    i_reset, i_valid, o_ready, o_valid, i_ready;
    alu_op_t i_op;
    data_t   i_operandA, i_operandB, o_result;

    int n_compared   = 0;
    int n_mismatched = 0;

    seq_alu #(.DATA_WIDTH(W)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_operandA (i_operandA),
        .i_operandB (i_operandB),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result)
    );

    always #5 i_clock = ~i_clock;

    // Reference model: RV32 semantics in plain 64-bit arithmetic.
    function automatic data_t model(alu_op_t op, data_t a, data_t b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        longint      p;
        logic [63:0] up;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $signed(a) >>> b[4:0];
            OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            OP_DIV:  begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            OP_REM:  begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
            OP_DIVU: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            OP_REMU: begin if (b == 0) return a;  p = ua % ub; return p[31:0]; end
            default: return '0;
        endcase
    endfunction

    function automatic int model_latency(alu_op_t op, data_t a, data_t b);
        if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU})
            return W + 1;
        if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
            if (b == 0)
                return 1;
            if ((op inside {OP_DIV, OP_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 1;
            return W + 1;
        end
        return 1;
    endfunction

    // Issues one request, scrambles inputs after acceptance, waits for the result
    // and consumes it. lat = cycles from acceptance to o_valid (0 on timeout).
    task automatic run_op(input alu_op_t op, input data_t a, input data_t b,
                          output data_t res, output int lat, output bit ready_while_busy);
        @(negedge i_clock);
        i_op = op; i_operandA = a; i_operandB = b; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clock);
        lat = 0;
        res = '0;
        ready_while_busy = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge i_clock);
            i_valid    = 1'b0;
            i_op       = alu_op_t'($urandom_range(0, 17));
            i_operandA = $urandom;
            i_operandB = $urandom;
            if (o_valid) begin
                lat = k;
                res = o_result;
                break;
            end
            if (o_ready) ready_while_busy = 1'b1;
        end
        @(posedge i_clock);
    endtask

    typedef struct {
        alu_op_t op;
        data_t   a;
        data_t   b;
        data_t   exp;
        int      lat;
        string   name;
    } vec_t;

    task automatic test_reset;
        i_reset = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
        i_op = OP_ADD; i_operandA = $urandom; i_operandB = $urandom;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0; i_valid = 1'b0;
        n_compared++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'h0) begin
            n_mismatched++;
            $display("FAIL reset_state: valid=%b ready=%b result=%h, required valid=0 ready=1 result=0",
                     o_valid, o_ready, o_result);
        end
        // Reset wins over a simultaneous consume + accept in DONE.
        i_op = OP_ADD; i_operandA = 32'd10; i_operandB = 32'd20; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1; i_ready = 1'b1; i_operandA = 32'd1;
        @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0; i_valid = 1'b0;
        n_compared++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'h0) begin
            n_mismatched++;
            $display("FAIL reset_priority: valid=%b ready=%b result=%h, required valid=0 ready=1 result=0",
                     o_valid, o_ready, o_result);
        end
    endtask

    task automatic test_directed;
        vec_t vecs[15] = '{
            '{OP_SRA,   32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1,     "sra"},
            '{OP_SRL,   32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1,     "srl"},
            '{OP_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1,     "slt"},
            '{OP_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1,     "sltu"},
            '{alu_op_t'(5'd25), 32'h1234_5678, 32'h1, 32'h0000_0000, 1,     "unknown_op"},
            '{OP_MUL,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, W + 1, "mul"},
            '{OP_MULH,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, W + 1, "mulh"},
            '{OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, W + 1, "mulhu"},
            '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, W + 1, "div"},
            '{OP_REM,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, W + 1, "rem"},
            '{OP_DIVU,  32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, 1,     "divu_by_zero"},
            '{OP_REMU,  32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1,     "remu_by_zero"},
            '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,     "div_overflow"},
            '{OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,     "rem_overflow"},
            '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1, "mulhsu"}
        };
        data_t res;
        int    lat;
        bit    rdy;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, rdy);
            n_compared++;
            if (res !== vecs[i].exp) begin
                n_mismatched++;
                $display("FAIL %s result: got %h, required %h", vecs[i].name, res, vecs[i].exp);
            end
            n_compared++;
            if (lat !== vecs[i].lat) begin
                n_mismatched++;
                $display("FAIL %s latency: got %0d, required %0d", vecs[i].name, lat, vecs[i].lat);
            end
            if (vecs[i].lat > 1) begin
                n_compared++;
                if (rdy !== 1'b0) begin
                    n_mismatched++;
                    $display("FAIL %s ready_while_busy: got %b, required 0", vecs[i].name, rdy);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge i_clock);
        i_op = OP_ADD; i_operandA = 32'h7FFF_FFFF; i_operandB = 32'h1; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clock);
        @(negedge i_clock);
        n_compared++;
        if (o_valid !== 1'b1 || o_result !== 32'h8000_0000 || o_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL b2b_add: valid=%b result=%h ready=%b, required valid=1 result=80000000 ready=1",
                     o_valid, o_result, o_ready);
        end
        i_op = OP_SUB; i_operandA = 32'd5; i_operandB = 32'd7;
        @(posedge i_clock);
        @(negedge i_clock);
        i_valid = 1'b0;
        n_compared++;
        if (o_valid !== 1'b1 || o_result !== 32'hFFFF_FFFE || o_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL b2b_sub: valid=%b result=%h ready=%b, required valid=1 result=fffffffe ready=1",
                     o_valid, o_result, o_ready);
        end
        @(posedge i_clock);
        @(negedge i_clock);
        n_compared++;
        if (o_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL b2b_drain: valid=%b, required 0", o_valid);
        end
    endtask

    task automatic test_backpressure;
        data_t   a0 = $urandom, b0 = $urandom, pa, pb, exp_held;
        alu_op_t pop;
        exp_held = a0 ^ b0;
        @(negedge i_clock);
        i_op = OP_XOR; i_operandA = a0; i_operandB = b0; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge i_clock);
        for (int c = 0; c < 6; c++) begin
            @(negedge i_clock);
            n_compared++;
            if (o_valid !== 1'b1 || o_result !== exp_held || o_ready !== 1'b0) begin
                n_mismatched++;
                $display("FAIL backpressure_hold cycle %0d: valid=%b result=%h ready=%b, required valid=1 result=%h ready=0",
                         c, o_valid, o_result, o_ready, exp_held);
            end
            i_op = alu_op_t'($urandom_range(0, 9));
            i_operandA = $urandom; i_operandB = $urandom;
            if (c < 5) @(posedge i_clock);
        end
        pop = alu_op_t'($urandom_range(0, 9)); pa = $urandom; pb = $urandom;
        i_op = pop; i_operandA = pa; i_operandB = pb; i_ready = 1'b1;
        @(posedge i_clock);
        @(negedge i_clock);
        i_valid = 1'b0;
        n_compared++;
        if (o_valid !== 1'b1 || o_result !== model(pop, pa, pb)) begin
            n_mismatched++;
            $display("FAIL backpressure_release: valid=%b result=%h, required valid=1 result=%h",
                     o_valid, o_result, model(pop, pa, pb));
        end
        @(posedge i_clock);
    endtask

    task automatic test_reset_mid_div;
        data_t res;
        int    lat;
        bit    rdy, leaked;
        @(negedge i_clock);
        i_op = OP_DIV; i_operandA = $urandom; i_operandB = $urandom_range(1, 1000);
        i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clock);
        @(negedge i_clock);
        i_valid = 1'b0;
        repeat (9) @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        n_compared++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reset_mid_div: valid=%b ready=%b, required valid=0 ready=1", o_valid, o_ready);
        end
        leaked = 1'b0;
        repeat (40) begin
            @(negedge i_clock);
            if (o_valid !== 1'b0) leaked = 1'b1;
        end
        n_compared++;
        if (leaked !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_mid_div_leak: partial result appeared=%b, required 0", leaked);
        end
        run_op(OP_ADD, 32'd3, 32'd4, res, lat, rdy);
        n_compared++;
        if (res !== 32'd7 || lat !== 1) begin
            n_mismatched++;
            $display("FAIL post_reset_add: result=%h latency=%0d, required 00000007 latency 1", res, lat);
        end
    endtask

    task automatic test_random;
        data_t   a, b, res;
        alu_op_t op;
        int      lat;
        bit      rdy;
        for (int n = 0; n < 80; n++) begin
            op = alu_op_t'($urandom_range(0, 19));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 50); b = $urandom_range(0, 9); end
                3: a = -$urandom_range(1, 50);
                default: ;
            endcase
            run_op(op, a, b, res, lat, rdy);
            n_compared++;
            if (res !== model(op, a, b)) begin
                n_mismatched++;
                $display("FAIL random_result op=%0d a=%h b=%h: got %h, required %h",
                         op, a, b, res, model(op, a, b));
            end
            n_compared++;
            if (lat !== model_latency(op, a, b)) begin
                n_mismatched++;
                $display("FAIL random_latency op=%0d a=%h b=%h: got %0d, required %0d",
                         op, a, b, lat, model_latency(op, a, b));
            end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_op = OP_ADD; i_operandA = '0; i_operandB = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_div();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
